cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Multicycle control unit for the 32-bit CPU, directly upstream of `alu`. It sequences fetch, decode, execute, memory and writeback through one Moore FSM. It drives the ALU select and operand muxes, the memory request handshake and the datapath register write strobes. It consumes the ALU `zero` and `ovf` flags to resolve branches and trap on signed overflow.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `opcode`, input, 4: IR[31:28], read from the instruction register.
- `alu_zero`, input, 1: ALU `zero` flag.
- `alu_ovf`, input, 1: ALU `ovf` flag.
- `mem_ack`, input, 1: memory completes the current request this cycle.
- `alu_sel`, output, 3: ALU operation; 0 ADD, 1 NOT, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 BEQ, 7 BNE.
- `alu_src_a`, output, 1: 0 = PC, 1 = rs.
- `alu_src_b`, output, 2: 0 = rt, 1 = constant 4, 2 = sext(imm16), 3 = sext(imm16)<<2.
- `mem_req`, output, 1: memory request, held until `mem_ack`.
- `mem_we`, output, 1: write request; valid only while `mem_req` = 1.
- `iord`, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write`, output, 1: load the instruction register.
- `pc_write`, output, 1: load the PC.
- `pc_src`, output, 1: PC source; 0 = ALU result, 1 = branch target register.
- `tgt_write`, output, 1: load the branch target register.
- `aluout_write`, output, 1: load ALUOut.
- `mdr_write`, output, 1: load the memory data register.
- `reg_write`, output, 1: write the register file at rd.
- `wb_src`, output, 1: writeback source; 0 = ALUOut, 1 = MDR.
- `trap`, output, 1: sticky fault indication.
- `retired`, output, RETIRE_W: count of completed instructions.

## Operation
- Opcodes 0–7 are the R-type ALU ops; `alu_sel` = opcode[2:0]. Opcode 8 is LW, 9 is SW, A is ADDI. Opcodes B–F are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Strobes not listed for a state are 0; mux selects not listed are don't-care.
- FETCH
  - Drive `mem_req` = 1, `iord` = 0, `alu_src_a` = PC, `alu_src_b` = 4, `alu_sel` = ADD.
  - On `mem_ack`: `ir_write` = 1, `pc_write` = 1, `pc_src` = 0, then go to DECODE. Otherwise stay in FETCH.
  - `alu_ovf` is ignored in this state.
- DECODE
  - Drive `alu_src_a` = PC, `alu_src_b` = 3, `alu_sel` = ADD, `tgt_write` = 1.
  - Illegal opcode: go to TRAP. Otherwise go to EXEC.
- EXEC, R-type ALU ops 0–5
  - Drive `alu_src_a` = rs, `alu_src_b` = rt, `alu_sel` = opcode[2:0].
  - ADD with `alu_ovf` = 1: `aluout_write` = 0, go to TRAP.
  - Otherwise: `aluout_write` = 1, go to WB.
- EXEC, ADDI
  - Drive `alu_src_a` = rs, `alu_src_b` = 2, `alu_sel` = ADD.
  - Overflow is handled as for ADD.
- EXEC, BEQ/BNE
  - Drive `alu_src_a` = rs, `alu_src_b` = rt, `alu_sel` = 6 or 7.
  - If `alu_zero` = 1, the branch is taken: `pc_write` = 1, `pc_src` = 1.
  - Go to FETCH and increment `retired`. The ALU raises `zero` for the taken condition of both ops, so the controller does not distinguish them.
- EXEC, LW/SW
  - Drive `alu_src_a` = rs, `alu_src_b` = 2, `alu_sel` = ADD, `aluout_write` = 1, then go to MEM.
  - `alu_ovf` is ignored (address wrap is legal).
- MEM
  - Drive `mem_req` = 1, `iord` = 1, `mem_we` = 1 for SW only.
  - On `mem_ack`: LW asserts `mdr_write` = 1 and goes to WB. SW goes to FETCH and increments `retired`.
- WB
  - Drive `reg_write` = 1, `wb_src` = 1 for LW and 0 otherwise.
  - Go to FETCH and increment `retired`.
- TRAP
  - All strobes 0, `mem_req` = 0, `trap` = 1.
  - Absorbing: only reset leaves TRAP.
- `retired` wraps modulo 2^RETIRE_W. It never increments for a trapping instruction.

## Timing
- Outputs are combinational decodes of the state and `opcode`; transitions are registered.
- Reset
  - While `rst_n` = 0 all outputs are forced to 0, including `trap` and `mem_req`.
  - At the first clock edge with `rst_n` = 0: state becomes FETCH and `retired` becomes 0.
  - In the first cycle after release, `mem_req` = 1.
- Reset mid-transaction: `mem_req` drops in the same cycle. A `mem_ack` arriving during reset is ignored.
- Handshake
  - `mem_req`, `mem_we` and `iord` are stable from assertion until the `mem_ack` cycle.
  - `mem_ack` is sampled only while `mem_req` = 1. An ack in the first request cycle gives zero wait states.
  - `mem_ack` outside FETCH/MEM has no effect.
- Cycles per instruction, zero wait states: ALU/ADDI 4, branch 3, LW 5, SW 4. Each memory wait cycle adds 1.
- `alu_zero` and `alu_ovf` are sampled only in EXEC, in the same cycle as the corresponding `alu_sel`.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants (OP_ADD … OP_ADDI);
  - ALU select constants shared with `alu`;
  - the `alu_src_b` and `pc_src` encodings;
  - the state enum.
- Sub-module `cpu_ctrl_decode` is combinational. It maps `opcode` to class flags: is_rtype, is_branch, is_mem, is_load, is_imm, is_illegal, chk_ovf.
- The FSM and the retire counter stay in `cpu_ctrl`.

## Test plan
- Reset then ADD, `mem_ack` tied to 1, no overflow:
  - states FETCH → DECODE → EXEC → WB → FETCH;
  - `reg_write` = 1 in cycle 4 only;
  - `retired` = 1 after 4 cycles.
- ADD with `alu_ovf` = 1 in EXEC:
  - `aluout_write` = 0, `reg_write` never asserted;
  - `trap` = 1 from the next cycle and held for 20 cycles;
  - `retired` stays 0.
- BEQ with `alu_zero` = 1, then BNE with `alu_zero` = 0:
  - `pc_write` = 1 with `pc_src` = 1 in the BEQ EXEC cycle only;
  - each branch takes 3 cycles; `retired` = 2.
- LW with `mem_ack` delayed 3 cycles in both FETCH and MEM:
  - `mem_req`, `iord` and `mem_we` stay stable throughout;
  - `mdr_write` = 1 on the MEM ack cycle, WB has `wb_src` = 1;
  - total 11 cycles.
- SW: MEM drives `mem_we` = 1, `iord` = 1; on ack goes straight to FETCH with no `reg_write`. Opcode 0xC: DECODE → TRAP.
- Assert `rst_n` = 0 mid-MEM while `mem_req` = 1:
  - `mem_req` = 0 in the same cycle;
  - after release, FETCH with `retired` = 0 and `trap` = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU select, mux encodings and FSM state for the CPU control unit
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_NOT  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_NOT = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_BEQ = 3'd6;
    localparam logic [2:0] ALU_BNE = 3'd7;

    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_RS      = 1'b1;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic       PC_SRC_ALU   = 1'b0;
    localparam logic       PC_SRC_TGT   = 1'b1;

    localparam logic       WB_ALUOUT    = 1'b0;
    localparam logic       WB_MDR       = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational opcode classifier for the control FSM
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_rtype,
    output logic       is_branch,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_imm,
    output logic       is_illegal,
    output logic       chk_ovf
);

    // Class flags; only ADD and ADDI trap on signed overflow
    always_comb begin
        is_rtype   = (opcode <= OP_SLL);
        is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_mem     = (opcode == OP_LW) || (opcode == OP_SW);
        is_load    = (opcode == OP_LW);
        is_imm     = (opcode == OP_ADDI);
        is_illegal = (opcode > OP_ADDI);
        chk_ovf    = (opcode == OP_ADD) || (opcode == OP_ADDI);
    end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multicycle Moore control FSM with retired-instruction counter
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          opcode,
    input  logic                alu_zero,
    input  logic                alu_ovf,
    input  logic                mem_ack,
    output logic [2:0]          alu_sel,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                tgt_write,
    output logic                aluout_write,
    output logic                mdr_write,
    output logic                reg_write,
    output logic                wb_src,
    output logic                trap,
    output logic [RETIRE_W-1:0] retired
);

    state_t                state;
    state_t                next_state;
    logic                  retire_inc;
    logic [RETIRE_W-1:0]   retired_q;

    logic is_rtype;
    logic is_branch;
    logic is_mem;
    logic is_load;
    logic is_imm;
    logic is_illegal;
    logic chk_ovf;

    cpu_ctrl_decode u_decode (
        .opcode     (opcode),
        .is_rtype   (is_rtype),
        .is_branch  (is_branch),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .is_imm     (is_imm),
        .is_illegal (is_illegal),
        .chk_ovf    (chk_ovf)
    );

    // Output decode and next-state selection; reset blanks every output so
    // a request in flight is withdrawn in the same cycle reset is seen
    always_comb begin
        next_state   = state;
        retire_inc   = 1'b0;
        alu_sel      = ALU_ADD;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        tgt_write    = 1'b0;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        reg_write    = 1'b0;
        wb_src       = WB_ALUOUT;
        trap         = 1'b0;
        retired      = retired_q;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH2;
                tgt_write  = 1'b1;
                next_state = is_illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                alu_src_a = SRCA_RS;
                if (is_branch) begin
                    // the ALU folds BEQ/BNE polarity into zero
                    alu_src_b  = SRCB_RT;
                    alu_sel    = opcode[2:0];
                    if (alu_zero) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_TGT;
                    end
                    next_state = S_FETCH;
                    retire_inc = 1'b1;
                end else if (is_mem) begin
                    // address arithmetic may wrap, so overflow is not checked
                    alu_src_b    = SRCB_IMM;
                    aluout_write = 1'b1;
                    next_state   = S_MEM;
                end else if (is_rtype || is_imm) begin
                    alu_src_b = is_imm ? SRCB_IMM : SRCB_RT;
                    alu_sel   = is_imm ? ALU_ADD : opcode[2:0];
                    if (chk_ovf && alu_ovf) begin
                        next_state = S_TRAP;
                    end else begin
                        aluout_write = 1'b1;
                        next_state   = S_WB;
                    end
                end else begin
                    next_state = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = !is_load;
                if (mem_ack) begin
                    if (is_load) begin
                        mdr_write  = 1'b1;
                        next_state = S_WB;
                    end else begin
                        next_state = S_FETCH;
                        retire_inc = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_src     = is_load ? WB_MDR : WB_ALUOUT;
                next_state = S_FETCH;
                retire_inc = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                next_state = S_TRAP;
            end
        endcase

        if (!rst_n) begin
            alu_sel      = 3'd0;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'd0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            iord         = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 1'b0;
            tgt_write    = 1'b0;
            aluout_write = 1'b0;
            mdr_write    = 1'b0;
            reg_write    = 1'b0;
            wb_src       = 1'b0;
            trap         = 1'b0;
            retired      = '0;
        end
    end

    // State register and wrapping retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            retired_q <= '0;
        end else begin
            state <= next_state;
            if (retire_inc) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - self-checking bench for cpu_ctrl against an instruction-level timing model
module tb_cpu_ctrl;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    opcode = 4'h0;
    logic          alu_zero = 1'b0;
    logic          alu_ovf = 1'b0;
    logic          mem_ack = 1'b0;
    logic [2:0]    alu_sel;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic          mem_req;
    logic          mem_we;
    logic          iord;
    logic          ir_write;
    logic          pc_write;
    logic          pc_src;
    logic          tgt_write;
    logic          aluout_write;
    logic          mdr_write;
    logic          reg_write;
    logic          wb_src;
    logic          trap;
    logic [RW-1:0] retired;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [RW-1:0] exp_ret = '0;

    cpu_ctrl #(.RETIRE_W(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .alu_zero     (alu_zero),
        .alu_ovf      (alu_ovf),
        .mem_ack      (mem_ack),
        .alu_sel      (alu_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .tgt_write    (tgt_write),
        .aluout_write (aluout_write),
        .mdr_write    (mdr_write),
        .reg_write    (reg_write),
        .wb_src       (wb_src),
        .trap         (trap),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       trp;
        int         regw;
        int         mdr;
        int         taken;
        int         aluw;
        int         memc;
        logic       exec_chk;
        logic [2:0] sel;
        logic [1:0] srcb;
        logic       wbs;
        logic       we;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level expectations: cycle counts, strobe counts, EXEC selects
    function automatic exp_t model(input logic [3:0] op, input logic z, input logic ov,
                                   input int fw, input int mw);
        exp_t e;
        e.cyc = 0; e.trp = 1'b0; e.regw = 0; e.mdr = 0; e.taken = 0; e.aluw = 0;
        e.memc = 0; e.exec_chk = 1'b1; e.sel = 3'd0; e.srcb = 2'd0; e.wbs = 1'b0; e.we = 1'b0;
        if (op >= 4'hB) begin
            e.cyc = fw + 2; e.trp = 1'b1; e.exec_chk = 1'b0;
        end else if (op == 4'h6 || op == 4'h7) begin
            e.sel = op[2:0]; e.cyc = fw + 3; e.taken = z ? 1 : 0;
        end else if (op == 4'h8 || op == 4'h9) begin
            e.srcb = 2'd2; e.aluw = 1; e.memc = mw + 1;
            if (op == 4'h8) begin
                e.cyc = fw + mw + 5; e.mdr = 1; e.regw = 1; e.wbs = 1'b1;
            end else begin
                e.cyc = fw + mw + 4; e.we = 1'b1;
            end
        end else begin
            e.sel  = (op == 4'hA) ? 3'd0 : op[2:0];
            e.srcb = (op == 4'hA) ? 2'd2 : 2'd0;
            if ((op == 4'h0 || op == 4'hA) && ov) begin
                e.cyc = fw + 3; e.trp = 1'b1;
            end else begin
                e.cyc = fw + 4; e.aluw = 1; e.regw = 1;
            end
        end
        return e;
    endfunction

    // Entered at a falling edge; leaves at a falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("reset outputs", 64'({alu_sel, alu_src_a, alu_src_b, mem_req, mem_we, iord, ir_write,
                                    pc_write, pc_src, tgt_write, aluout_write, mdr_write, reg_write,
                                    wb_src, trap, retired}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b0;
        #1;
        check("release mem_req", 64'(mem_req), 64'd1);
        check("release iord", 64'(iord), 64'd0);
        check("release retired", 64'(retired), 64'd0);
        check("release trap", 64'(trap), 64'd0);
        exp_ret = '0;
    endtask

    // Acts as memory (fw/mw wait cycles) and tallies strobes until retire or trap
    task automatic run_instr(input logic [3:0] op, input logic z, input logic ov,
                             input int fw, input int mw);
        exp_t          e;
        logic [RW-1:0] start;
        string         p;
        int cyc = 0, regw = 0, mdr = 0, taken = 0, pcw = 0, aluw = 0, irw = 0, tgtw = 0;
        int memc = 0, req_cnt = 0, stab = 0, weerr = 0, wbs_bad = 0;
        logic f_we = 1'b0, f_iord = 1'b0;
        logic [2:0] sel_o = 3'd0;
        logic [1:0] srcb_o = 2'd0;
        logic       srca_o = 1'b0;
        bit done = 1'b0;
        e = model(op, z, ov, fw, mw);
        p = $sformatf("op%0h fw%0d mw%0d", op, fw, mw);
        opcode = op;
        alu_zero = z;
        alu_ovf = ov;
        start = retired;
        while (!done) begin
            if (retired !== start || trap === 1'b1 || cyc >= 60) begin
                done = 1'b1;
            end else begin
                mem_ack = 1'b0;
                #1;
                if (mem_req === 1'b1) mem_ack = (req_cnt == (iord ? mw : fw));
                #1;
                cyc++;
                if (reg_write === 1'b1) begin
                    regw++;
                    if (wb_src !== e.wbs) wbs_bad++;
                end
                if (mdr_write === 1'b1) mdr++;
                if (pc_write === 1'b1) pcw++;
                if (pc_write === 1'b1 && pc_src === 1'b1) taken++;
                if (aluout_write === 1'b1) aluw++;
                if (ir_write === 1'b1) irw++;
                if (tgt_write === 1'b1) tgtw++;
                if (mem_req === 1'b1) begin
                    if (iord === 1'b1) begin
                        memc++;
                        if (mem_we !== e.we) weerr++;
                    end else if (mem_we !== 1'b0) begin
                        weerr++;
                    end
                    if (req_cnt == 0) begin
                        f_we = mem_we;
                        f_iord = iord;
                    end else if (mem_we !== f_we || iord !== f_iord) begin
                        stab++;
                    end
                    req_cnt = mem_ack ? 0 : req_cnt + 1;
                end else begin
                    req_cnt = 0;
                end
                if (cyc == fw + 3) begin
                    sel_o = alu_sel;
                    srcb_o = alu_src_b;
                    srca_o = alu_src_a;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        if (!e.trp) exp_ret = exp_ret + 1'b1;
        check({p, " cycles"}, 64'(cyc), 64'(e.cyc));
        check({p, " trap"}, 64'(trap), 64'(e.trp));
        check({p, " retired"}, 64'(retired), 64'(exp_ret));
        check({p, " reg_write count"}, 64'(regw), 64'(e.regw));
        check({p, " mdr_write count"}, 64'(mdr), 64'(e.mdr));
        check({p, " branch taken count"}, 64'(taken), 64'(e.taken));
        check({p, " pc_write count"}, 64'(pcw), 64'(1 + e.taken));
        check({p, " aluout_write count"}, 64'(aluw), 64'(e.aluw));
        check({p, " ir_write count"}, 64'(irw), 64'd1);
        check({p, " tgt_write count"}, 64'(tgtw), 64'd1);
        check({p, " mem phase cycles"}, 64'(memc), 64'(e.memc));
        check({p, " handshake stability"}, 64'(stab), 64'd0);
        check({p, " mem_we errors"}, 64'(weerr), 64'd0);
        check({p, " wb_src errors"}, 64'(wbs_bad), 64'd0);
        if (e.exec_chk) begin
            check({p, " exec alu_sel"}, 64'(sel_o), 64'(e.sel));
            check({p, " exec alu_src_b"}, 64'(srcb_o), 64'(e.srcb));
            check({p, " exec alu_src_a"}, 64'(srca_o), 64'd1);
        end
    endtask

    task automatic trap_hold(input string tag);
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            if (trap !== 1'b1 || mem_req !== 1'b0 || reg_write !== 1'b0 ||
                pc_write !== 1'b0 || retired !== exp_ret) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check({tag, " trap hold"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        @(negedge clk);
        do_reset();

        run_instr(4'h0, 1'b0, 1'b0, 0, 0);
        run_instr(4'h6, 1'b1, 1'b0, 0, 0);
        run_instr(4'h7, 1'b0, 1'b0, 0, 0);
        run_instr(4'h8, 1'b0, 1'b1, 3, 3);
        run_instr(4'h9, 1'b1, 1'b1, 0, 1);
        run_instr(4'hA, 1'b0, 1'b0, 1, 0);
        run_instr(4'h3, 1'b0, 1'b1, 0, 0);
        run_instr(4'h1, 1'b1, 1'b0, 0, 0);
        run_instr(4'h2, 1'b0, 1'b0, 2, 0);
        run_instr(4'h4, 1'b0, 1'b0, 0, 0);
        run_instr(4'h5, 1'b1, 1'b1, 0, 0);

        // Reset while MEM has a request outstanding
        opcode = 4'h8;
        alu_zero = 1'b0;
        alu_ovf = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #1;
        check("mid-mem mem_req", 64'(mem_req), 64'd1);
        check("mid-mem iord", 64'(iord), 64'd1);
        check("mid-mem retired before reset", 64'(retired), 64'(exp_ret));
        do_reset();

        run_instr(4'h0, 1'b0, 1'b1, 0, 0);
        trap_hold("add ovf");
        do_reset();

        run_instr(4'hC, 1'b0, 1'b0, 1, 0);
        trap_hold("illegal C");
        do_reset();

        run_instr(4'hA, 1'b1, 1'b1, 0, 0);
        do_reset();

        // Enough branches to wrap the narrow retire counter
        for (int i = 0; i < 17; i++) begin
            run_instr(4'($urandom_range(6, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), 0);
        end

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 11));
            if (op == 4'hB) op = 4'($urandom_range(11, 15));
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if (trap === 1'b1) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
